// File: rtl/fixed_divide_seq.sv
// Iterative unsigned Q-format divider: restoring shift-subtract,
// one quotient bit per clock, with remainder, div-by-zero and overflow.
module fixed_divide_seq #(
  parameter int DATA_WIDTH     = 32,
  parameter int FRAC_BIT_COUNT = DATA_WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  ready,
  output logic                  busy,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int N  = DATA_WIDTH + FRAC_BIT_COUNT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]          num;
  logic [N-1:0]          quo;
  logic [N-1:0]          quo_nx;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] den;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   rem_nx;
  logic [CW-1:0]         cnt;
  logic                  qbit;
  logic                  last;
  logic                  zero_div;
  logic                  ovf;

  // Remainder stays below the divisor, so DATA_WIDTH bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    shifted  = {rem, num[N-1]};
    qbit     = shifted >= {1'b0, den};
    rem_nx   = qbit ? shifted - {1'b0, den} : shifted;
    quo_nx   = {quo[N-2:0], qbit};
    last     = cnt == CW'(1);
    zero_div = divisor == '0;
    ovf      = |quo_nx[N-1:DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !zero_div) state_nx = RUN;
      RUN:  if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = state == RUN;

  always_ff @(posedge clk) begin
    if (reset) begin
      num         <= '0;
      quo         <= '0;
      rem         <= '0;
      den         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (state == IDLE) begin
        if (start && zero_div) begin
          quotient    <= '1;
          remainder   <= '0;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
          ready       <= 1'b1;
        end else if (start) begin
          num <= {dividend, {FRAC_BIT_COUNT{1'b0}}};
          den <= divisor;
          rem <= '0;
          quo <= '0;
          cnt <= CW'(N);
        end
      end else begin
        num <= {num[N-2:0], 1'b0};
        rem <= rem_nx[DATA_WIDTH-1:0];
        quo <= quo_nx;
        cnt <= cnt - CW'(1);
        if (last) begin
          remainder   <= rem_nx[DATA_WIDTH-1:0];
          overflow    <= ovf;
          quotient    <= ovf ? '1 : quo_nx[DATA_WIDTH-1:0];
          div_by_zero <= 1'b0;
          ready       <= 1'b1;
        end
      end
    end
  end

endmodule
